// File: rtl/fle_pkg.sv
// Shared types and configuration field layout for the fracturable logic element.
package fle_pkg;

    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } cfg_state_t;

    // Mode-bit offsets above the 2^K-entry LUT table.
    localparam int CFG_FRAC        = 0;
    localparam int CFG_REG_SEL0    = 1;
    localparam int CFG_REG_SEL1    = 2;
    localparam int CFG_FF_IN_SEL0  = 3;
    localparam int CFG_FF_IN_SEL1  = 4;
    localparam int CFG_MODE_BITS   = 5;

    function automatic int cfg_bits(input int k);
        return (1 << k) + CFG_MODE_BITS;
    endfunction

    function automatic int cfg_field(input int k, input int offset);
        return (1 << k) + offset;
    endfunction

endpackage

// File: rtl/fle_ccff_chain.sv
// Configuration shift chain with load-length tracking; declares the element
// ready only after a full-length (or longer) shift burst.
module fle_ccff_chain
    import fle_pkg::*;
#(
    parameter int LUT_K = 4,
    localparam int CFG_BITS = cfg_bits(LUT_K)
) (
    input  logic                fle_clk,
    input  logic                fle_reset_n,
    input  logic                ccff_en,
    input  logic                ccff_head,
    output logic [CFG_BITS-1:0] cfg,
    output logic                ccff_tail,
    output logic                cfg_ready
);

    localparam int CNT_W = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    cfg_state_t       state, state_next;
    logic [CNT_W-1:0] count, count_next;

    always_ff @(posedge fle_clk or negedge fle_reset_n) begin
        if (!fle_reset_n) begin
            cfg   <= '0;
            state <= UNCONF;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (ccff_en)
                cfg <= {cfg[CFG_BITS-2:0], ccff_head};
        end
    end

    // The edge that leaves UNCONF/READY already shifts a bit, so the fresh
    // count starts at one rather than zero.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            UNCONF, READY: begin
                if (ccff_en) begin
                    state_next = LOADING;
                    count_next = CNT_W'(1);
                end
            end
            LOADING: begin
                if (ccff_en) begin
                    if (count != CNT_MAX)
                        count_next = count + 1'b1;
                end else begin
                    state_next = (count == CNT_MAX) ? READY : UNCONF;
                end
            end
            default: state_next = UNCONF;
        endcase
    end

    assign ccff_tail = cfg[CFG_BITS-1];
    assign cfg_ready = (state == READY);

endmodule

// File: rtl/fle_frac_param.sv
// Fracturable K-input logic element: one K-LUT or two (K-1)-LUTs, two output
// flip-flops with register-chain and scan paths, outputs gated until configured.
module fle_frac_param
    import fle_pkg::*;
#(
    parameter int LUT_K = 4
) (
    input  logic             fle_clk,
    input  logic             fle_reset_n,
    input  logic             Test_en,
    input  logic [LUT_K-1:0] fle_in,
    input  logic             fle_reg_in,
    input  logic             fle_sc_in,
    input  logic             ccff_en,
    input  logic             ccff_head,
    output logic [1:0]       fle_out,
    output logic             fle_reg_out,
    output logic             fle_sc_out,
    output logic             ccff_tail,
    output logic             cfg_ready
);

    localparam int CFG_BITS = cfg_bits(LUT_K);
    localparam int TBL_SIZE = 1 << LUT_K;
    localparam int IDX_FRAC       = cfg_field(LUT_K, CFG_FRAC);
    localparam int IDX_REG_SEL0   = cfg_field(LUT_K, CFG_REG_SEL0);
    localparam int IDX_REG_SEL1   = cfg_field(LUT_K, CFG_REG_SEL1);
    localparam int IDX_FF_IN_SEL0 = cfg_field(LUT_K, CFG_FF_IN_SEL0);
    localparam int IDX_FF_IN_SEL1 = cfg_field(LUT_K, CFG_FF_IN_SEL1);

    logic [CFG_BITS-1:0] cfg;
    logic [TBL_SIZE-1:0] lut_table;
    logic                frac, reg_sel0, reg_sel1, ff_in_sel0, ff_in_sel1;
    logic [LUT_K-1:0]    lo_idx, hi_idx;
    logic                lut_lo, lut_hi, lut_full, lut0, lut1;
    logic                ff0_q, ff1_q, ff0_d, ff1_d;

    fle_ccff_chain #(
        .LUT_K (LUT_K)
    ) u_ccff_chain (
        .fle_clk     (fle_clk),
        .fle_reset_n (fle_reset_n),
        .ccff_en     (ccff_en),
        .ccff_head   (ccff_head),
        .cfg         (cfg),
        .ccff_tail   (ccff_tail),
        .cfg_ready   (cfg_ready)
    );

    assign lut_table  = cfg[TBL_SIZE-1:0];
    assign frac       = cfg[IDX_FRAC];
    assign reg_sel0   = cfg[IDX_REG_SEL0];
    assign reg_sel1   = cfg[IDX_REG_SEL1];
    assign ff_in_sel0 = cfg[IDX_FF_IN_SEL0];
    assign ff_in_sel1 = cfg[IDX_FF_IN_SEL1];

    // The table splits into a low and high half selected by the top input.
    assign lo_idx   = {1'b0, fle_in[LUT_K-2:0]};
    assign hi_idx   = {1'b1, fle_in[LUT_K-2:0]};
    assign lut_lo   = lut_table[lo_idx];
    assign lut_hi   = lut_table[hi_idx];
    assign lut_full = fle_in[LUT_K-1] ? lut_hi : lut_lo;
    assign lut0     = frac ? lut_lo : lut_full;
    assign lut1     = lut_hi;

    assign ff0_d = ff_in_sel0 ? fle_reg_in : lut0;
    assign ff1_d = ff_in_sel1 ? ff0_q : lut1;

    // Scan wins in any config state; functional capture only when configured
    // and not reloading.
    always_ff @(posedge fle_clk or negedge fle_reset_n) begin
        if (!fle_reset_n) begin
            ff0_q <= 1'b0;
            ff1_q <= 1'b0;
        end else if (Test_en) begin
            ff0_q <= fle_sc_in;
            ff1_q <= ff0_q;
        end else if (cfg_ready && !ccff_en) begin
            ff0_q <= ff0_d;
            ff1_q <= ff1_d;
        end
    end

    always_comb begin
        fle_out = 2'b00;
        if (cfg_ready && !Test_en) begin
            fle_out[0] = reg_sel0 ? ff0_q : lut0;
            fle_out[1] = reg_sel1 ? ff1_q : lut1;
        end
    end

    assign fle_reg_out = ff1_q;
    assign fle_sc_out  = ff1_q;

endmodule

// File: tb/tb_fle_frac_param.sv
// Directed self-checking bench for fle_frac_param at LUT_K=4 (21 config bits).
module tb_fle_frac_param;

    logic       fle_clk = 1'b0;
    logic       fle_reset_n;
    logic       Test_en;
    logic [3:0] fle_in;
    logic       fle_reg_in;
    logic       fle_sc_in;
    logic       ccff_en;
    logic       ccff_head;
    logic [1:0] fle_out;
    logic       fle_reg_out;
    logic       fle_sc_out;
    logic       ccff_tail;
    logic       cfg_ready;

    int n_checks = 0;
    int n_fail   = 0;

    fle_frac_param #(
        .LUT_K (4)
    ) dut (
        .fle_clk     (fle_clk),
        .fle_reset_n (fle_reset_n),
        .Test_en     (Test_en),
        .fle_in      (fle_in),
        .fle_reg_in  (fle_reg_in),
        .fle_sc_in   (fle_sc_in),
        .ccff_en     (ccff_en),
        .ccff_head   (ccff_head),
        .fle_out     (fle_out),
        .fle_reg_out (fle_reg_out),
        .fle_sc_out  (fle_sc_out),
        .ccff_tail   (ccff_tail),
        .cfg_ready   (cfg_ready)
    );

    always #5 fle_clk = ~fle_clk;

    task automatic step();
        @(posedge fle_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Word layout is {ff_in_sel1, ff_in_sel0, reg_sel1, reg_sel0, frac, table}; MSB goes first.
    task automatic applyStimulus(input logic [20:0] word);
        for (int i = 20; i >= 0; i--) begin
            ccff_en   = 1'b1;
            ccff_head = word[i];
            step();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
        step();
    endtask

    initial begin
        fle_reset_n = 1'b0;
        Test_en     = 1'b0;
        fle_in      = 4'h0;
        fle_reg_in  = 1'b0;
        fle_sc_in   = 1'b0;
        ccff_en     = 1'b0;
        ccff_head   = 1'b0;
        #12;
        checkOutput("reset_out",     32'(fle_out),     32'h0);
        checkOutput("reset_ready",   32'(cfg_ready),   32'h0);
        checkOutput("reset_tail",    32'(ccff_tail),   32'h0);
        checkOutput("reset_reg_out", 32'(fle_reg_out), 32'h0);
        fle_reset_n = 1'b1;

        // Reset in the middle of a load discards everything.
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
        for (int i = 0; i < 22; i++) step();
        checkOutput("midload_tail_before", 32'(ccff_tail), 32'h1);
        checkOutput("midload_ready_before", 32'(cfg_ready), 32'h0);
        fle_reset_n = 1'b0;
        #1;
        checkOutput("midload_tail_reset",  32'(ccff_tail), 32'h0);
        checkOutput("midload_ready_reset", 32'(cfg_ready), 32'h0);
        checkOutput("midload_out_reset",   32'(fle_out),   32'h0);
        ccff_en     = 1'b0;
        ccff_head   = 1'b0;
        #1;
        fle_reset_n = 1'b1;

        // Full 4-LUT: table 16'h8000, all modes 0.
        applyStimulus({5'b00000, 16'h8000});
        checkOutput("full_ready", 32'(cfg_ready), 32'h1);
        fle_in = 4'hF; #1;
        checkOutput("full_in_F", 32'(fle_out), 32'h3);
        fle_in = 4'hE; #1;
        checkOutput("full_in_E", 32'(fle_out), 32'h0);
        fle_in = 4'h7; #1;
        checkOutput("full_in_7", 32'(fle_out), 32'h2);

        // Fractured: lo = XOR3 (8'h96), hi = AND3 (8'h80).
        applyStimulus({5'b00001, 16'h8096});
        fle_in = 4'b0111; #1;
        checkOutput("frac_111", 32'(fle_out), 32'h3);
        fle_in = 4'b0011; #1;
        checkOutput("frac_011", 32'(fle_out), 32'h0);
        fle_in = 4'b1001; #1;
        checkOutput("frac_001_top_ignored", 32'(fle_out), 32'h1);

        // Registered outputs follow one cycle later; reload freezes the FFs.
        applyStimulus({5'b00111, 16'h8096});
        fle_in = 4'b0011;
        step();
        checkOutput("regd_settle", 32'(fle_out), 32'h0);
        fle_in = 4'b0111; #1;
        checkOutput("regd_pre_7", 32'(fle_out), 32'h0);
        step();
        checkOutput("regd_post_7", 32'(fle_out), 32'h3);
        fle_in = 4'b0001; #1;
        checkOutput("regd_pre_1", 32'(fle_out), 32'h3);
        step();
        checkOutput("regd_post_1", 32'(fle_out), 32'h1);
        ccff_en   = 1'b1;
        ccff_head = 1'b0;
        fle_in    = 4'b0111;
        step();
        checkOutput("reload_out",   32'(fle_out),     32'h0);
        checkOutput("reload_ready", 32'(cfg_ready),   32'h0);
        checkOutput("reload_hold",  32'(fle_reg_out), 32'h0);
        ccff_en = 1'b0;
        step();
        checkOutput("one_shift_unconf", 32'(cfg_ready), 32'h0);

        // Register chain: both ff_in_sel set.
        applyStimulus({5'b11000, 16'h0000});
        checkOutput("chain_ready", 32'(cfg_ready), 32'h1);
        fle_reg_in = 1'b0;
        step();
        step();
        checkOutput("chain_idle", 32'(fle_reg_out), 32'h0);
        fle_reg_in = 1'b1;
        step();
        fle_reg_in = 1'b0;
        checkOutput("chain_cycle1", 32'(fle_reg_out), 32'h0);
        step();
        checkOutput("chain_cycle2",  32'(fle_reg_out), 32'h1);
        checkOutput("chain_sc_out",  32'(fle_sc_out),  32'h1);
        checkOutput("chain_fle_out", 32'(fle_out),     32'h0);
        step();
        checkOutput("chain_cycle3", 32'(fle_reg_out), 32'h0);

        // Short load of 20 bits falls back to UNCONF.
        ccff_en   = 1'b1;
        ccff_head = 1'b0;
        for (int i = 0; i < 20; i++) step();
        ccff_en = 1'b0;
        step();
        checkOutput("short_load_ready", 32'(cfg_ready), 32'h0);
        checkOutput("short_load_out",   32'(fle_out),   32'h0);

        // Scan while unconfigured.
        Test_en   = 1'b1;
        fle_sc_in = 1'b1;
        step();
        fle_sc_in = 1'b0;
        step();
        checkOutput("scan_bit0", 32'(fle_sc_out), 32'h1);
        checkOutput("scan_out0", 32'(fle_out),    32'h0);
        fle_sc_in = 1'b1;
        step();
        checkOutput("scan_bit1", 32'(fle_sc_out), 32'h0);
        fle_sc_in = 1'b0;
        step();
        checkOutput("scan_bit2", 32'(fle_sc_out), 32'h1);

        // 26-bit over-long load while scanning: first bit reaches the tail on edge 21.
        for (int n = 1; n <= 26; n++) begin
            ccff_en   = 1'b1;
            ccff_head = (n == 1 || n == 26);
            step();
            if (n == 20) checkOutput("tail_edge20", 32'(ccff_tail), 32'h0);
            if (n == 21) checkOutput("tail_edge21", 32'(ccff_tail), 32'h1);
            if (n == 22) checkOutput("tail_edge22", 32'(ccff_tail), 32'h0);
            if (n == 21) checkOutput("scan_load_out", 32'(fle_out), 32'h0);
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
        step();
        checkOutput("overlong_ready",   32'(cfg_ready), 32'h1);
        checkOutput("overlong_test_en", 32'(fle_out),   32'h0);
        Test_en = 1'b0;
        fle_in  = 4'h0; #1;
        checkOutput("overlong_in_0", 32'(fle_out), 32'h1);
        fle_in  = 4'h8; #1;
        checkOutput("overlong_in_8", 32'(fle_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
